// File: rtl/acc_dispatch_queue_if.sv
// Handshake bundle between issue/commit stages, the dispatch queue and the vector unit.
// The master side drives the queue; the slave side is the queue itself.
interface acc_dispatch_queue_if #(
    parameter int DEPTH         = 4,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     flush_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [31:0]              in_instr_i;
    logic [XLEN-1:0]          in_rs1_i;
    logic [XLEN-1:0]          in_rs2_i;
    logic [TRANS_ID_BITS-1:0] in_trans_id_i;
    logic                     commit_i;
    logic [TRANS_ID_BITS-1:0] commit_trans_id_i;
    logic                     commit_err_o;
    logic                     acc_valid_o;
    logic                     acc_ready_i;
    logic [31:0]              acc_instr_o;
    logic [XLEN-1:0]          acc_rs1_o;
    logic [XLEN-1:0]          acc_rs2_o;
    logic [TRANS_ID_BITS-1:0] acc_trans_id_o;
    logic [CNT_W-1:0]         count_o;

    modport master (
        output flush_i, in_valid_i, in_instr_i, in_rs1_i, in_rs2_i, in_trans_id_i,
               commit_i, commit_trans_id_i, acc_ready_i,
        input  in_ready_o, commit_err_o, acc_valid_o, acc_instr_o, acc_rs1_o,
               acc_rs2_o, acc_trans_id_o, count_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_rs1_i, in_rs2_i, in_trans_id_i,
               commit_i, commit_trans_id_i, acc_ready_i,
        output in_ready_o, commit_err_o, acc_valid_o, acc_instr_o, acc_rs1_o,
               acc_rs2_o, acc_trans_id_o, count_o
    );
endinterface

// File: rtl/acc_dispatch_queue.sv
// Vector-instruction dispatch queue: entries are held until committed, then offered
// in order to the vector unit; uncommitted entries can be squashed by flush.
module acc_dispatch_queue #(
    parameter int DEPTH         = 4,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    acc_dispatch_queue_if.slave  q
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [31:0]              instr;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    // head <= cmt <= tail; pointers carry one extra bit to tell full from empty
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cmt_q, cmt_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             commit_err_q, commit_err_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic [PTR_W-1:0] count;
    logic             full;
    logic             in_ready;
    logic             enq;
    logic             cmt_ok;
    logic             acc_valid;
    logic             deq;
    entry_t           head_entry;

    always_comb begin
        count      = tail_q - head_q;
        full       = (count == PTR_W'(DEPTH));
        in_ready   = !full && !q.flush_i;
        enq        = q.in_valid_i && in_ready;
        cmt_ok     = q.commit_i && (cmt_q != tail_q) &&
                     (q.commit_trans_id_i == mem_q[cmt_q[IDX_W-1:0]].trans_id);
        acc_valid  = (head_q != cmt_q);
        deq        = acc_valid && q.acc_ready_i;
        head_entry = mem_q[head_q[IDX_W-1:0]];

        head_d       = head_q;
        cmt_d        = cmt_q;
        tail_d       = tail_q;
        commit_err_d = q.commit_i && !cmt_ok;
        mem_d        = mem_q;

        if (deq)    head_d = head_q + PTR_W'(1);
        if (cmt_ok) cmt_d  = cmt_q + PTR_W'(1);
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
            mem_d[tail_q[IDX_W-1:0]] = '{instr:    q.in_instr_i,
                                         rs1:      q.in_rs1_i,
                                         rs2:      q.in_rs2_i,
                                         trans_id: q.in_trans_id_i};
        end
        // flush keeps whatever got committed this same cycle
        if (q.flush_i) tail_d = cmt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q       <= '0;
            cmt_q        <= '0;
            tail_q       <= '0;
            commit_err_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            cmt_q        <= cmt_d;
            tail_q       <= tail_d;
            commit_err_q <= commit_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign q.in_ready_o     = in_ready;
    assign q.count_o        = count;
    assign q.commit_err_o   = commit_err_q;
    assign q.acc_valid_o    = acc_valid;
    assign q.acc_instr_o    = head_entry.instr;
    assign q.acc_rs1_o      = head_entry.rs1;
    assign q.acc_rs2_o      = head_entry.rs2;
    assign q.acc_trans_id_o = head_entry.trans_id;
endmodule

// File: tb/tb_acc_dispatch_queue.sv
// Bench for acc_dispatch_queue: directed vector table, corner-case sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_acc_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int TIDB  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_dispatch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TIDB)) ifc ();

    acc_dispatch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .q     (ifc.slave)
    );

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [TIDB-1:0] id;
    } ent_t;

    // model: list of live entries, oldest first; the first m_nc of them are committed
    ent_t m_q[$];
    int   m_nc  = 0;
    logic m_err = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle's inputs and compare combinational outputs with the model
    task automatic apply(input logic r, input logic fl, input logic iv, input logic [TIDB-1:0] id,
                         input logic cm, input logic [TIDB-1:0] cid, input logic ar);
        logic m_rdy, m_av;
        rst                   = r;
        ifc.flush_i           = fl;
        ifc.in_valid_i        = iv;
        ifc.in_trans_id_i     = id;
        ifc.in_instr_i        = $urandom;
        ifc.in_rs1_i          = {$urandom, $urandom};
        ifc.in_rs2_i          = {$urandom, $urandom};
        ifc.commit_i          = cm;
        ifc.commit_trans_id_i = cid;
        ifc.acc_ready_i       = ar;
        #1;
        m_rdy = (m_q.size() < DEPTH) && !fl;
        m_av  = (m_nc > 0);
        chk("in_ready", 64'(ifc.in_ready_o), 64'(m_rdy));
        chk("acc_valid", 64'(ifc.acc_valid_o), 64'(m_av));
        chk("count", 64'(ifc.count_o), 64'(m_q.size()));
        chk("commit_err", 64'(ifc.commit_err_o), 64'(m_err));
        if (m_av) begin
            chk("acc_id", 64'(ifc.acc_trans_id_o), 64'(m_q[0].id));
            chk("acc_instr", 64'(ifc.acc_instr_o), 64'(m_q[0].instr));
            chk("acc_rs1", ifc.acc_rs1_o, m_q[0].rs1);
            chk("acc_rs2", ifc.acc_rs2_o, m_q[0].rs2);
        end
    endtask

    // clock edge: advance the model with the applied inputs, then idle the inputs
    task automatic clock();
        logic enq, deq, cok;
        ent_t e;
        enq = ifc.in_valid_i && (m_q.size() < DEPTH) && !ifc.flush_i;
        deq = (m_nc > 0) && ifc.acc_ready_i;
        cok = ifc.commit_i && (m_nc < m_q.size()) && (m_q[m_nc].id == ifc.commit_trans_id_i);
        e   = '{ifc.in_instr_i, ifc.in_rs1_i, ifc.in_rs2_i, ifc.in_trans_id_i};
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_nc  = 0;
            m_err = 1'b0;
        end else begin
            m_err = ifc.commit_i && !cok;
            if (cok) m_nc++;
            if (deq) begin
                void'(m_q.pop_front());
                m_nc--;
            end
            if (ifc.flush_i) while (m_q.size() > m_nc) void'(m_q.pop_back());
            if (enq) m_q.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        ifc.flush_i = 1'b0; ifc.in_valid_i = 1'b0; ifc.commit_i = 1'b0; ifc.acc_ready_i = 1'b0;
    endtask

    task automatic idle_check();
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic            iv;
        logic [TIDB-1:0] id;
        logic            cm;
        logic [TIDB-1:0] cid;
        logic            ar;
        logic            e_rdy;
        logic            e_av;
        logic [TIDB-1:0] e_id;
        logic [2:0]      e_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // enqueue 1,2,3; commit 1 then 2; drain: only 1 and 2 get offered
        tbl[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 2, 0, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{1, 3, 1, 1, 0, 1, 0, 0, 2};
        tbl[3] = '{0, 0, 1, 2, 1, 1, 1, 1, 3};
        tbl[4] = '{0, 0, 0, 0, 1, 1, 1, 2, 2};
        tbl[5] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};

        ifc.flush_i = 0; ifc.in_valid_i = 0; ifc.commit_i = 0; ifc.acc_ready_i = 0;
        ifc.in_instr_i = 0; ifc.in_rs1_i = 0; ifc.in_rs2_i = 0;
        ifc.in_trans_id_i = 0; ifc.commit_trans_id_i = 0;
        @(negedge clk);
        apply(1, 0, 0, 0, 0, 0, 0); clock();
        apply(1, 0, 0, 0, 0, 0, 0); clock();
        idle_check();
        chk("rst_count", 64'(ifc.count_o), 0);
        chk("rst_valid", 64'(ifc.acc_valid_o), 0);
        chk("rst_err", 64'(ifc.commit_err_o), 0);
        chk("rst_ready", 64'(ifc.in_ready_o), 1);

        for (int i = 0; i < 6; i++) begin
            apply(0, 0, tbl[i].iv, tbl[i].id, tbl[i].cm, tbl[i].cid, tbl[i].ar);
            chk($sformatf("tbl%0d_ready", i), 64'(ifc.in_ready_o), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(ifc.acc_valid_o), 64'(tbl[i].e_av));
            chk($sformatf("tbl%0d_count", i), 64'(ifc.count_o), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_err", i), 64'(ifc.commit_err_o), 0);
            if (tbl[i].e_av) chk($sformatf("tbl%0d_id", i), 64'(ifc.acc_trans_id_o), 64'(tbl[i].e_id));
            clock();
        end
        apply(0, 1, 0, 0, 0, 0, 0); clock();  // drop leftover ID 3

        // fill, no bypass on the full cycle, then wrap 12 ops through
        for (int i = 0; i < 4; i++) begin apply(0, 0, 1, 3'(i), 0, 0, 0); clock(); end
        idle_check();
        chk("full_ready", 64'(ifc.in_ready_o), 0);
        chk("full_count", 64'(ifc.count_o), 4);
        apply(0, 0, 1, 7, 1, 0, 0); clock();
        apply(0, 0, 1, 7, 1, 1, 1);
        chk("full_deq_ready", 64'(ifc.in_ready_o), 0);
        clock();
        idle_check();
        chk("after_deq_ready", 64'(ifc.in_ready_o), 1);
        chk("after_deq_count", 64'(ifc.count_o), 3);
        apply(0, 0, 0, 0, 1, 2, 1); clock();
        apply(0, 0, 0, 0, 1, 3, 1); clock();
        for (int i = 0; i < 14; i++) begin
            apply(0, 0, (i < 12), 3'(i), (i > 0 && i < 13), 3'(i - 1), 1); clock();
        end
        idle_check();
        chk("wrap_count", 64'(ifc.count_o), 0);

        // flush keeps committed 5, next enqueue lands after it
        apply(0, 0, 1, 5, 0, 0, 0); clock();
        apply(0, 0, 1, 6, 0, 0, 0); clock();
        apply(0, 0, 1, 7, 0, 0, 0); clock();
        apply(0, 0, 0, 0, 1, 5, 0); clock();
        apply(0, 1, 0, 0, 0, 0, 0); clock();
        idle_check();
        chk("flush_count", 64'(ifc.count_o), 1);
        chk("flush_id", 64'(ifc.acc_trans_id_o), 5);
        apply(0, 0, 1, 0, 0, 0, 1); clock();
        idle_check();
        chk("flush_new_count", 64'(ifc.count_o), 1);
        chk("flush_new_valid", 64'(ifc.acc_valid_o), 0);
        apply(0, 0, 0, 0, 1, 0, 0); clock();
        apply(0, 0, 0, 0, 0, 0, 1);
        chk("flush_new_id", 64'(ifc.acc_trans_id_o), 0);
        clock();

        // commit mismatch and commit on empty
        apply(0, 0, 1, 5, 0, 0, 0); clock();
        apply(0, 0, 1, 6, 0, 0, 0); clock();
        apply(0, 0, 0, 0, 1, 6, 0); clock();
        idle_check();
        chk("mismatch_err", 64'(ifc.commit_err_o), 1);
        chk("mismatch_valid", 64'(ifc.acc_valid_o), 0);
        clock();
        idle_check();
        chk("err_pulse_end", 64'(ifc.commit_err_o), 0);
        apply(0, 0, 0, 0, 1, 5, 0); clock();
        apply(0, 1, 0, 0, 0, 0, 1);
        chk("cmt_kept_id", 64'(ifc.acc_trans_id_o), 5);
        clock();
        apply(0, 0, 0, 0, 1, 2, 0); clock();
        idle_check();
        chk("empty_err", 64'(ifc.commit_err_o), 1);
        clock();

        // commit and flush in the same cycle
        apply(0, 0, 1, 5, 0, 0, 0); clock();
        apply(0, 0, 1, 6, 0, 0, 0); clock();
        apply(0, 1, 0, 0, 1, 5, 0); clock();
        idle_check();
        chk("cf_count", 64'(ifc.count_o), 1);
        chk("cf_id", 64'(ifc.acc_trans_id_o), 5);
        apply(0, 0, 0, 0, 0, 0, 1); clock();
        idle_check();
        chk("cf_drained", 64'(ifc.count_o), 0);

        // reset mid-operation wins over everything
        apply(0, 0, 1, 1, 0, 0, 0); clock();
        apply(0, 0, 1, 2, 1, 1, 0); clock();
        apply(0, 0, 1, 3, 1, 2, 0); clock();
        idle_check();
        chk("pre_rst_valid", 64'(ifc.acc_valid_o), 1);
        apply(1, 1, 1, 4, 1, 3, 1); clock();
        idle_check();
        chk("mid_rst_count", 64'(ifc.count_o), 0);
        chk("mid_rst_valid", 64'(ifc.acc_valid_o), 0);
        chk("mid_rst_ready", 64'(ifc.in_ready_o), 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [TIDB-1:0] cid;
            cid = 3'($urandom);
            if (m_nc < m_q.size() && $urandom_range(0, 3) != 0) cid = m_q[m_nc].id;
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 6), 3'($urandom), ($urandom_range(0, 9) < 4),
                  cid, ($urandom_range(0, 9) < 6));
            clock();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
